ctrl_fsm: RTL and testbench

Multi-cycle control sequencer for the WRAMP core; the successor to the purely combinational opcode decoder. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB states, and drives the PC, IR, ALU, register-file and memory-port controls per state. It handshakes with a variable-latency memory over req/ack and traps illegal opcodes and bus timeouts. It sits between the instruction register and the datapath, replacing the single-cycle decode path.

---
 rtl/wramp_pkg.sv | 42 ++++
 rtl/ctrl_fsm_if.sv | 35 +++
 rtl/ctrl_fsm_op_classify.sv | 30 +++
 rtl/ctrl_fsm.sv | 177 +++++++++++++++++
 tb/tb_ctrl_fsm.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/wramp_pkg.sv
// rtl/wramp_pkg.sv - shared WRAMP opcode, state and write-back encodings
package wramp_pkg;

    localparam logic [3:0] OP_RR   = 4'b0000;
    localparam logic [3:0] OP_RI   = 4'b0001;
    localparam logic [3:0] OP_LHI  = 4'b0011;
    localparam logic [3:0] OP_J    = 4'b0100;
    localparam logic [3:0] OP_JR   = 4'b0101;
    localparam logic [3:0] OP_JAL  = 4'b0110;
    localparam logic [3:0] OP_LW   = 4'b1000;
    localparam logic [3:0] OP_SW   = 4'b1001;
    localparam logic [3:0] OP_BEQZ = 4'b1010;
    localparam logic [3:0] OP_BNEZ = 4'b1011;

    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_MEM  = 2'd1;
    localparam logic [1:0] WB_LINK = 2'd2;

    typedef enum logic [2:0] {
        ST_RESET,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_FAULT
    } state_t;

    typedef enum logic [3:0] {
        CL_ILL,
        CL_RR,
        CL_RI,
        CL_LW,
        CL_SW,
        CL_J,
        CL_JR,
        CL_JAL,
        CL_BEQZ,
        CL_BNEZ
    } op_class_t;

endpackage

// File: rtl/ctrl_fsm_if.sv
// rtl/ctrl_fsm_if.sv - control sequencer to IR/datapath/memory signal bundle
interface ctrl_fsm_if #(
    parameter int OP_W   = 4,
    parameter int FUNC_W = 4
);
    logic [OP_W-1:0]   op_code;
    logic [FUNC_W-1:0] func_in;
    logic              rs_zero;
    logic              mem_ack;
    logic              mem_req;
    logic              mem_we;
    logic              addr_sel;
    logic              ir_load;
    logic              pc_inc;
    logic              pc_load;
    logic              jr;
    logic [FUNC_W-1:0] alu_func;
    logic              alu_b_imm;
    logic              reg_write;
    logic [1:0]        wb_sel;
    logic              illegal;
    logic              bus_err;

    modport master (
        input  op_code, func_in, rs_zero, mem_ack,
        output mem_req, mem_we, addr_sel, ir_load, pc_inc, pc_load, jr,
               alu_func, alu_b_imm, reg_write, wb_sel, illegal, bus_err
    );

    modport slave (
        output op_code, func_in, rs_zero, mem_ack,
        input  mem_req, mem_we, addr_sel, ir_load, pc_inc, pc_load, jr,
               alu_func, alu_b_imm, reg_write, wb_sel, illegal, bus_err
    );
endinterface

// File: rtl/ctrl_fsm_op_classify.sv
// rtl/ctrl_fsm_op_classify.sv - combinational opcode to instruction-class decode
module op_classify
    import wramp_pkg::*;
#(
    parameter int OP_W = 4
) (
    input  logic [OP_W-1:0] op_code,
    output op_class_t       op_class,
    output logic            legal
);

    always_comb begin
        op_class = CL_ILL;
        case (op_code)
            OP_W'(OP_RR):   op_class = CL_RR;
            OP_W'(OP_RI):   op_class = CL_RI;
            OP_W'(OP_LHI):  op_class = CL_RI;
            OP_W'(OP_J):    op_class = CL_J;
            OP_W'(OP_JR):   op_class = CL_JR;
            OP_W'(OP_JAL):  op_class = CL_JAL;
            OP_W'(OP_LW):   op_class = CL_LW;
            OP_W'(OP_SW):   op_class = CL_SW;
            OP_W'(OP_BEQZ): op_class = CL_BEQZ;
            OP_W'(OP_BNEZ): op_class = CL_BNEZ;
            default:        op_class = CL_ILL;
        endcase
        legal = (op_class != CL_ILL);
    end

endmodule

// File: rtl/ctrl_fsm.sv
// rtl/ctrl_fsm.sv - multi-cycle WRAMP control sequencer with memory handshake and traps
module ctrl_fsm
    import wramp_pkg::*;
#(
    parameter int OP_W        = 4,
    parameter int FUNC_W      = 4,
    parameter int ADD_FUNC    = 0,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic      clk,
    input  logic      rst,
    ctrl_fsm_if.master bus
);

    localparam int CNT_W = 16;
    localparam logic [FUNC_W-1:0] ADD_F = FUNC_W'(ADD_FUNC);

    state_t          state, state_next;
    op_class_t       op_class_q;
    op_class_t       dec_class;
    logic            dec_legal;
    logic            illegal_q;
    logic            bus_err_q;
    logic [CNT_W-1:0] wait_cnt;
    logic            in_req;
    logic            timeout_hit;

    op_classify #(.OP_W(OP_W)) u_classify (
        .op_code  (bus.op_code),
        .op_class (dec_class),
        .legal    (dec_legal)
    );

    assign in_req = (state == ST_FETCH) || (state == ST_MEM);

    // An ack landing on the final permitted cycle takes priority over the timeout.
    assign timeout_hit = (ACK_TIMEOUT != 0) && in_req && !bus.mem_ack &&
                         (wait_cnt == CNT_W'(ACK_TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_RESET;
            op_class_q <= CL_ILL;
            illegal_q  <= 1'b0;
            bus_err_q  <= 1'b0;
            wait_cnt   <= '0;
        end else begin
            state <= state_next;
            if (state == ST_DECODE) begin
                op_class_q <= dec_legal ? dec_class : CL_ILL;
            end
            if (state == ST_EXEC && op_class_q == CL_ILL) begin
                illegal_q <= 1'b1;
            end
            if (timeout_hit) begin
                bus_err_q <= 1'b1;
            end
            if ((state_next == ST_FETCH || state_next == ST_MEM) && state_next != state) begin
                wait_cnt <= '0;
            end else if (in_req && !bus.mem_ack) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.illegal = illegal_q;
    assign bus.bus_err = bus_err_q;

    always_comb begin
        state_next    = state;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.addr_sel  = 1'b0;
        bus.ir_load   = 1'b0;
        bus.pc_inc    = 1'b0;
        bus.pc_load   = 1'b0;
        bus.jr        = 1'b0;
        bus.alu_func  = '0;
        bus.alu_b_imm = 1'b0;
        bus.reg_write = 1'b0;
        bus.wb_sel    = WB_ALU;

        case (state)
            ST_RESET: state_next = ST_FETCH;

            ST_FETCH: begin
                bus.mem_req = 1'b1;
                if (bus.mem_ack) begin
                    bus.ir_load = 1'b1;
                    bus.pc_inc  = 1'b1;
                    state_next  = ST_DECODE;
                end else if (timeout_hit) begin
                    state_next = ST_FAULT;
                end
            end

            ST_DECODE: state_next = ST_EXEC;

            ST_EXEC: begin
                case (op_class_q)
                    CL_RR: begin
                        bus.alu_func = bus.func_in;
                        state_next   = ST_WB;
                    end
                    CL_RI: begin
                        bus.alu_func  = bus.func_in;
                        bus.alu_b_imm = 1'b1;
                        state_next    = ST_WB;
                    end
                    CL_LW, CL_SW: begin
                        bus.alu_func  = ADD_F;
                        bus.alu_b_imm = 1'b1;
                        state_next    = ST_MEM;
                    end
                    CL_J: begin
                        bus.alu_func = ADD_F;
                        bus.pc_load  = 1'b1;
                        state_next   = ST_FETCH;
                    end
                    CL_JR: begin
                        bus.alu_func = ADD_F;
                        bus.pc_load  = 1'b1;
                        bus.jr       = 1'b1;
                        state_next   = ST_FETCH;
                    end
                    // Link write and jump share the cycle so the link sees the incremented PC.
                    CL_JAL: begin
                        bus.pc_load   = 1'b1;
                        bus.reg_write = 1'b1;
                        bus.wb_sel    = WB_LINK;
                        state_next    = ST_FETCH;
                    end
                    CL_BEQZ: begin
                        bus.pc_load = bus.rs_zero;
                        state_next  = ST_FETCH;
                    end
                    CL_BNEZ: begin
                        bus.pc_load = !bus.rs_zero;
                        state_next  = ST_FETCH;
                    end
                    default: state_next = ST_FAULT;
                endcase
            end

            ST_MEM: begin
                bus.mem_req   = 1'b1;
                bus.addr_sel  = 1'b1;
                bus.mem_we    = (op_class_q == CL_SW);
                bus.alu_func  = ADD_F;
                bus.alu_b_imm = 1'b1;
                if (bus.mem_ack) begin
                    state_next = (op_class_q == CL_LW) ? ST_WB : ST_FETCH;
                end else if (timeout_hit) begin
                    state_next = ST_FAULT;
                end
            end

            ST_WB: begin
                bus.reg_write = 1'b1;
                if (op_class_q == CL_LW) begin
                    bus.wb_sel    = WB_MEM;
                    bus.alu_func  = ADD_F;
                    bus.alu_b_imm = 1'b1;
                end else begin
                    bus.alu_func  = bus.func_in;
                    bus.alu_b_imm = (op_class_q == CL_RI);
                end
                state_next = ST_FETCH;
            end

            ST_FAULT: state_next = ST_FAULT;

            default: state_next = ST_RESET;
        endcase
    end

endmodule

// File: tb/tb_ctrl_fsm.sv
// tb/tb_ctrl_fsm.sv - directed self-checking bench for ctrl_fsm
module tb_ctrl_fsm;

    localparam logic [14:0] REQ  = 15'h4000;
    localparam logic [14:0] WE   = 15'h2000;
    localparam logic [14:0] ASEL = 15'h1000;
    localparam logic [14:0] IRL  = 15'h0800;
    localparam logic [14:0] PCI  = 15'h0400;
    localparam logic [14:0] PCL  = 15'h0200;
    localparam logic [14:0] JRB  = 15'h0100;
    localparam logic [14:0] IMM  = 15'h0080;
    localparam logic [14:0] RW   = 15'h0040;
    localparam logic [14:0] WBL  = 15'h0020;
    localparam logic [14:0] WBM  = 15'h0010;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    ctrl_fsm_if #(.OP_W(4), .FUNC_W(4)) bus ();

    ctrl_fsm #(
        .OP_W(4), .FUNC_W(4), .ADD_FUNC(0), .ACK_TIMEOUT(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [14:0] ov();
        return {bus.mem_req, bus.mem_we, bus.addr_sel, bus.ir_load, bus.pc_inc,
                bus.pc_load, bus.jr, bus.alu_b_imm, bus.reg_write, bus.wb_sel, bus.alu_func};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        chk({tag, "_out"}, 32'(ov()), 32'h0);
        chk({tag, "_flags"}, {30'd0, bus.illegal, bus.bus_err}, 32'h0);
        cyc();
        rst = 1'b0;
        #1;
        chk({tag, "_rststate"}, 32'(ov()), 32'h0);
        cyc();
    endtask

    // Starts in the first FETCH cycle; ends at the first EXEC cycle.
    task automatic fetch(input string tag, input logic [3:0] op, input logic [3:0] fn, input int waits);
        bus.op_code = op;
        bus.func_in = fn;
        for (int i = 0; i < waits; i++) begin
            bus.mem_ack = 1'b0;
            #1;
            chk({tag, "_fwait"}, 32'(ov()), 32'(REQ));
            cyc();
        end
        bus.mem_ack = 1'b1;
        #1;
        chk({tag, "_fack"}, 32'(ov()), 32'(REQ | IRL | PCI));
        cyc();
        bus.mem_ack = 1'b0;
        #1;
        chk({tag, "_decode"}, 32'(ov()), 32'h0);
        cyc();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        bus.op_code = 4'h0;
        bus.func_in = 4'h0;
        bus.rs_zero = 1'b0;
        bus.mem_ack = 1'b0;
        rst = 1'b0;
        #1;
        do_reset("reset");

        fetch("rr", 4'h0, 4'h3, 2);
        #1 chk("rr_exec", 32'(ov()), 32'h3);
        cyc();
        #1 chk("rr_wb", 32'(ov()), 32'(RW | 15'h3));
        cyc();

        fetch("lw", 4'h8, 4'h5, 1);
        #1 chk("lw_exec", 32'(ov()), 32'(IMM));
        cyc();
        bus.mem_ack = 1'b1;
        #1 chk("lw_mem", 32'(ov()), 32'(REQ | ASEL | IMM));
        cyc();
        bus.mem_ack = 1'b0;
        #1 chk("lw_wb", 32'(ov()), 32'(RW | WBM | IMM));
        cyc();

        fetch("sw", 4'h9, 4'h5, 1);
        #1 chk("sw_exec", 32'(ov()), 32'(IMM));
        cyc();
        #1 chk("sw_mem_wait", 32'(ov()), 32'(REQ | WE | ASEL | IMM));
        cyc();
        bus.mem_ack = 1'b1;
        #1 chk("sw_mem_ack", 32'(ov()), 32'(REQ | WE | ASEL | IMM));
        cyc();
        bus.mem_ack = 1'b0;

        fetch("beqz1", 4'hA, 4'h0, 1);
        bus.rs_zero = 1'b1;
        #1 chk("beqz_taken", 32'(ov()), 32'(PCL));
        bus.rs_zero = 1'b0;
        #1 chk("beqz_follow", 32'(ov()), 32'h0);
        cyc();
        fetch("beqz0", 4'hA, 4'h0, 0);
        #1 chk("beqz_not", 32'(ov()), 32'h0);
        cyc();
        fetch("bnez", 4'hB, 4'h0, 0);
        #1 chk("bnez_taken", 32'(ov()), 32'(PCL));
        bus.rs_zero = 1'b1;
        #1 chk("bnez_not", 32'(ov()), 32'h0);
        bus.rs_zero = 1'b0;
        cyc();

        fetch("jal", 4'h6, 4'h0, 0);
        #1 chk("jal_exec", 32'(ov()), 32'(PCL | RW | WBL));
        cyc();
        fetch("jr", 4'h5, 4'h0, 0);
        #1 chk("jr_exec", 32'(ov()), 32'(PCL | JRB));
        cyc();
        fetch("j", 4'h4, 4'h0, 0);
        #1 chk("j_exec", 32'(ov()), 32'(PCL));
        cyc();

        fetch("lhi", 4'h3, 4'h9, 0);
        #1 chk("lhi_exec", 32'(ov()), 32'(IMM | 15'h9));
        cyc();
        #1 chk("lhi_wb", 32'(ov()), 32'(RW | IMM | 15'h9));
        cyc();

        // Ack on the 4th request cycle: no timeout.
        fetch("ack4", 4'h1, 4'h2, 3);
        #1 chk("ack4_exec", 32'(ov()), 32'(IMM | 15'h2));
        chk("ack4_buserr", {31'd0, bus.bus_err}, 32'h0);
        cyc();
        #1 chk("ack4_wb", 32'(ov()), 32'(RW | IMM | 15'h2));
        cyc();

        bus.mem_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1 chk("to_req", 32'(ov()), 32'(REQ));
            chk("to_noerr", {31'd0, bus.bus_err}, 32'h0);
            cyc();
        end
        #1 chk("to_fault_out", 32'(ov()), 32'h0);
        chk("to_buserr", {30'd0, bus.illegal, bus.bus_err}, 32'h1);
        cyc();
        do_reset("to_rst");

        fetch("ill", 4'hF, 4'h0, 0);
        #1 chk("ill_exec", 32'(ov()), 32'h0);
        cyc();
        for (int i = 0; i < 20; i++) begin
            bus.mem_ack = i[0];
            #1 chk("ill_fault_out", 32'(ov()), 32'h0);
            chk("ill_flags", {30'd0, bus.illegal, bus.bus_err}, 32'h2);
            cyc();
        end
        bus.mem_ack = 1'b0;
        do_reset("ill_rst");

        fetch("midmem", 4'h8, 4'h0, 0);
        cyc();
        #1 chk("midmem_req", 32'(ov()), 32'(REQ | ASEL | IMM));
        #2 rst = 1'b1;
        #1 chk("midmem_async", 32'(ov()), 32'h0);
        cyc();
        rst = 1'b0;
        cyc();
        fetch("recover", 4'h1, 4'h7, 0);
        #1 chk("recover_exec", 32'(ov()), 32'(IMM | 15'h7));
        cyc();
        #1 chk("recover_wb", 32'(ov()), 32'(RW | IMM | 15'h7));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
